// File: rtl/present_pkg.sv
// present_pkg: shared definitions for the PRESENT-80 CBC byte-stream front-end.
//   - BLK_W / KEY_W        : cipher block and key widths
//   - BYTES_PER_BLK, CNT_W : bytes per block and width of the byte counters
//   - state_e              : front-end FSM states
package present_pkg;

  localparam int unsigned BLK_W         = 64;
  localparam int unsigned KEY_W         = 80;
  localparam int unsigned BYTES_PER_BLK = 8;
  localparam int unsigned CNT_W         = $clog2(BYTES_PER_BLK);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_KICK,
    ST_WAIT,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/present_byte_ser.sv
// present_byte_ser: 64-bit load / byte shift-out serializer.
//   clk, rst   : clock and synchronous active-high reset
//   load       : capture load_data and restart the byte count
//   load_data  : block to serialize
//   adv        : output handshake, advance to the next byte
//   byte_out   : current byte (first byte = [63:56] when MSB_FIRST, else [7:0])
//   last       : current byte is the final byte of the block
module present_byte_ser
  import present_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [BLK_W-1:0] load_data,
  input  logic             adv,
  output logic [7:0]       byte_out,
  output logic             last
);

  logic [BLK_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load) begin
      sr_d  = load_data;
      cnt_d = '0;
    end else if (adv) begin
      sr_d  = MSB_FIRST ? {sr_q[BLK_W-9:0], 8'h00} : {8'h00, sr_q[BLK_W-1:8]};
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign byte_out = MSB_FIRST ? sr_q[BLK_W-1 -: 8] : sr_q[7:0];
  assign last     = (cnt_q == CNT_W'(BYTES_PER_BLK - 1));

endmodule

// File: rtl/present_cbc_stream.sv
// present_cbc_stream: byte-stream CBC front-end for a PRESENT-80 core.
//   CK, RN                 : clock, synchronous active-high reset
//   cfg_load/cfg_key/cfg_iv: load key and IV (only when idle with no partial block)
//   in_data/valid/ready    : plaintext byte stream
//   out_data/valid/ready   : ciphertext byte stream
//   core_start/ptext/key   : request to the cipher core
//   core_ready/ctext       : response from the cipher core
//   blk_cnt                : completed-block counter (wraps)
module present_cbc_stream
  import present_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             cfg_load,
  input  logic [KEY_W-1:0] cfg_key,
  input  logic [BLK_W-1:0] cfg_iv,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             core_start,
  output logic [BLK_W-1:0] core_ptext,
  output logic [KEY_W-1:0] core_key,
  input  logic             core_ready,
  input  logic [BLK_W-1:0] core_ctext,
  output logic [15:0]      blk_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [BLK_W-1:0] block_q, block_d;
  logic [BLK_W-1:0] chain_q, chain_d;
  logic [BLK_W-1:0] ptext_q, ptext_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [15:0]      blk_cnt_q, blk_cnt_d;
  logic             wait_arm_q, wait_arm_d;

  logic             in_acc, load_ok, capture, out_hs, ser_last, last_in;
  logic [BLK_W-1:0] block_shift;

  assign in_acc  = in_valid & in_ready;
  assign last_in = in_acc & (bcnt_q == CNT_W'(BYTES_PER_BLK - 1));
  assign load_ok = cfg_load & (state_q == ST_FILL) & (bcnt_q == '0);
  // The core response is only trusted from the second WAIT cycle onward.
  assign capture = (state_q == ST_WAIT) & wait_arm_q & core_ready;
  assign out_hs  = out_valid & out_ready;

  // State register
  always_ff @(posedge CK) begin
    if (RN) state_q <= ST_FILL;
    else    state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FILL:  if (last_in)             state_d = ST_KICK;
      ST_KICK:                           state_d = ST_WAIT;
      ST_WAIT:  if (capture)             state_d = ST_DRAIN;
      ST_DRAIN: if (out_hs && ser_last)  state_d = ST_FILL;
      default:                           state_d = ST_FILL;
    endcase
  end

  // Outputs; all handshake strobes are held off while reset is asserted.
  always_comb begin
    in_ready   = 1'b0;
    core_start = 1'b0;
    out_valid  = 1'b0;
    unique case (state_q)
      ST_FILL:  in_ready   = !cfg_load && !RN;
      ST_KICK:  core_start = !RN;
      ST_DRAIN: out_valid  = !RN;
      default:  ;
    endcase
  end

  // Datapath next values
  always_comb begin
    bcnt_d     = bcnt_q;
    block_d    = block_q;
    chain_d    = chain_q;
    ptext_d    = ptext_q;
    key_d      = key_q;
    blk_cnt_d  = blk_cnt_q;
    wait_arm_d = (state_q == ST_WAIT);

    block_shift = MSB_FIRST ? {block_q[BLK_W-9:0], in_data}
                            : {in_data, block_q[BLK_W-1:8]};

    if (load_ok) begin
      key_d     = cfg_key;
      chain_d   = cfg_iv;
      blk_cnt_d = '0;
    end

    if (in_acc) begin
      block_d = block_shift;
      bcnt_d  = bcnt_q + CNT_W'(1);
      if (last_in) ptext_d = block_shift ^ chain_q;
    end

    if (capture) chain_d = core_ctext;

    if (out_hs && ser_last) begin
      blk_cnt_d = blk_cnt_q + 16'd1;
      bcnt_d    = '0;
    end
  end

  always_ff @(posedge CK) begin
    if (RN) begin
      bcnt_q     <= '0;
      block_q    <= '0;
      chain_q    <= '0;
      ptext_q    <= '0;
      key_q      <= '0;
      blk_cnt_q  <= '0;
      wait_arm_q <= 1'b0;
    end else begin
      bcnt_q     <= bcnt_d;
      block_q    <= block_d;
      chain_q    <= chain_d;
      ptext_q    <= ptext_d;
      key_q      <= key_d;
      blk_cnt_q  <= blk_cnt_d;
      wait_arm_q <= wait_arm_d;
    end
  end

  present_byte_ser #(
    .MSB_FIRST(MSB_FIRST)
  ) u_ser (
    .clk      (CK),
    .rst      (RN),
    .load     (capture),
    .load_data(core_ctext),
    .adv      (out_hs),
    .byte_out (out_data),
    .last     (ser_last)
  );

  assign core_ptext = ptext_q;
  assign core_key   = key_q;
  assign blk_cnt    = blk_cnt_q;

endmodule

// File: tb/tb_present_cbc_stream.sv
// tb_present_cbc_stream: scoreboard bench for present_cbc_stream with a
// behavioural PRESENT-80 core model.
module tb_present_cbc_stream;

  logic        CK = 1'b0;
  logic        RN = 1'b1;
  logic        cfg_load = 1'b0;
  logic [79:0] cfg_key = '0;
  logic [63:0] cfg_iv = '0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        core_start;
  logic [63:0] core_ptext;
  logic [79:0] core_key;
  logic        core_ready = 1'b0;
  logic [63:0] core_ctext = 64'hDEAD_BEEF_CAFE_F00D;
  logic [15:0] blk_cnt;

  present_cbc_stream #(.MSB_FIRST(1'b1)) dut (
    .CK(CK), .RN(RN), .cfg_load(cfg_load), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .core_start(core_start), .core_ptext(core_ptext), .core_key(core_key),
    .core_ready(core_ready), .core_ctext(core_ctext), .blk_cnt(blk_cnt)
  );

  always #5 CK = ~CK;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [7:0]  exp_out_q[$];
  logic [63:0] exp_pt_q[$];
  logic [79:0] exp_key_q[$];

  logic [63:0] m_chain = '0;
  logic [79:0] m_key   = '0;
  logic [15:0] exp_blk = '0;

  bit          bp_mode    = 1'b0;
  bit          core_early = 1'b0;
  bit          core_hang  = 1'b0;
  int unsigned core_lat   = 2;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
    endcase
  endfunction

  function automatic logic [63:0] present80(input logic [63:0] p, input logic [79:0] k_in);
    logic [63:0] s, t;
    logic [79:0] k;
    s = p;
    k = k_in;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int j = 0; j < 16; j++) s[4*j +: 4] = sbox(s[4*j +: 4]);
      t = '0;
      for (int i = 0; i < 63; i++) t[(i*16) % 63] = s[i];
      t[63] = s[63];
      s = t;
      k = {k[18:0], k[79:19]};
      k[79:76] = sbox(k[79:76]);
      k[19:15] = k[19:15] ^ r[4:0];
    end
    return s ^ k[79:16];
  endfunction

  // out_ready driver: constant 1, or toggling each cycle under back-pressure
  initial forever begin
    @(posedge CK); #1;
    out_ready = bp_mode ? ~out_ready : 1'b1;
  end

  // Output monitor / scoreboard, plus in_ready and start-pulse checks
  initial begin
    bit          busy = 1'b0;
    bit          hold_pending = 1'b0;
    bit          prev_start = 1'b0;
    logic [7:0]  held = '0;
    int unsigned byte_cnt = 0;
    forever begin
      @(negedge CK);
      if (prev_start) chk("start_one_cycle", 80'(core_start), 80'(0));
      prev_start = core_start;
      if (RN) begin
        busy = 1'b0;
        hold_pending = 1'b0;
      end else begin
        if (core_start) busy = 1'b1;
        if (busy) chk("in_ready_busy", 80'(in_ready), 80'(0));
        if (out_valid) begin
          if (hold_pending) chk("out_data_stable", 80'(out_data), 80'(held));
          if (out_ready) begin
            hold_pending = 1'b0;
            chk("out_expected", 80'(exp_out_q.size() != 0), 80'(1));
            if (exp_out_q.size() != 0) chk("out_byte", 80'(out_data), 80'(exp_out_q.pop_front()));
            byte_cnt++;
            if (byte_cnt % 8 == 0) busy = 1'b0;
          end else begin
            hold_pending = 1'b1;
            held = out_data;
          end
        end
      end
    end
  end

  // Core model
  initial forever begin
    logic [63:0] ct, pt_hold;
    logic [79:0] key_hold;
    int unsigned t;
    @(negedge CK);
    if (core_start && !RN) begin
      chk("pt_expected", 80'(exp_pt_q.size() != 0), 80'(1));
      if (exp_pt_q.size() != 0) chk("core_ptext", 80'(core_ptext), 80'(exp_pt_q.pop_front()));
      if (exp_key_q.size() != 0) chk("core_key", core_key, exp_key_q.pop_front());
      pt_hold  = core_ptext;
      key_hold = core_key;
      ct = present80(core_ptext, core_key);
      if (!core_hang) begin
        if (core_early) begin
          core_ready = 1'b1;
          core_ctext = ~ct;
          @(posedge CK);
          @(posedge CK); #1;
          core_ctext = ct;
        end else begin
          repeat (core_lat) @(posedge CK);
          #1;
          core_ready = 1'b1;
          core_ctext = ct;
        end
        t = 0;
        @(negedge CK);
        while (!out_valid && t < 50) begin
          chk("ptext_stable", 80'(core_ptext), 80'(pt_hold));
          chk("key_stable", core_key, key_hold);
          @(negedge CK);
          t++;
        end
        chk("core_capture_timeout", 80'(t < 50), 80'(1));
        core_ready = 1'b0;
        core_ctext = 64'hDEAD_BEEF_CAFE_F00D;
      end
    end
  end

  // Stimulus tasks: each starts and ends 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    int unsigned t = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge CK);
    while (!in_ready && t < 200) begin
      @(negedge CK);
      t++;
    end
    chk("in_accept_timeout", 80'(in_ready), 80'(1));
    @(posedge CK); #1;
    in_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [63:0] pt, input bit use_hand, input logic [63:0] hand,
                          input bit expect_out);
    logic [63:0] ptx, ct;
    ptx = pt ^ m_chain;
    exp_pt_q.push_back(ptx);
    exp_key_q.push_back(m_key);
    ct = use_hand ? hand : present80(ptx, m_key);
    if (expect_out) for (int i = 0; i < 8; i++) exp_out_q.push_back(ct[63-8*i -: 8]);
    m_chain = ct;
  endtask

  task automatic send_range(input logic [63:0] pt, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_byte(pt[63-8*i -: 8]);
  endtask

  task automatic send_block(input logic [63:0] pt, input bit use_hand, input logic [63:0] hand);
    push_exp(pt, use_hand, hand, 1'b1);
    send_range(pt, 0, 7);
  endtask

  task automatic cfg_pulse(input logic [79:0] k, input logic [63:0] iv,
                           input bit with_byte, input logic [7:0] b);
    cfg_key  = k;
    cfg_iv   = iv;
    cfg_load = 1'b1;
    if (with_byte) begin
      in_valid = 1'b1;
      in_data  = b;
    end
    @(negedge CK);
    chk("in_ready_during_cfg", 80'(in_ready), 80'(0));
    @(posedge CK); #1;
    cfg_load = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int unsigned t = 0;
    @(negedge CK);
    while ((exp_out_q.size() != 0 || out_valid) && t < 400) begin
      @(negedge CK);
      t++;
    end
    chk("drain_timeout", 80'(t < 400), 80'(1));
    chk(name, 80'(blk_cnt), 80'(exp_blk));
    @(posedge CK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(posedge CK);
    @(negedge CK);
    chk("rst_in_ready", 80'(in_ready), 80'(0));
    chk("rst_out_valid", 80'(out_valid), 80'(0));
    chk("rst_core_start", 80'(core_start), 80'(0));
    chk("rst_out_data", 80'(out_data), 80'(0));
    chk("rst_blk_cnt", 80'(blk_cnt), 80'(0));
    chk("rst_core_key", core_key, 80'(0));
    chk("rst_core_ptext", 80'(core_ptext), 80'(0));
    @(posedge CK); #1;
    RN = 1'b0;
    @(negedge CK);
    chk("in_ready_after_rst", 80'(in_ready), 80'(1));
    @(posedge CK); #1;

    // Zero vector, then chaining on it
    cfg_pulse('0, '0, 1'b0, 8'h00);
    m_key = '0;
    m_chain = '0;
    send_block(64'h0, 1'b1, 64'h5579_C138_7B22_8445);
    exp_blk = 16'd1;
    wait_done("blk_cnt_zero_vec");
    send_block(64'h0, 1'b0, 64'h0);
    exp_blk = 16'd2;
    wait_done("blk_cnt_chain");

    // All-ones vector
    cfg_pulse({80{1'b1}}, '0, 1'b0, 8'h00);
    m_key = {80{1'b1}};
    m_chain = '0;
    send_block({64{1'b1}}, 1'b1, 64'h3333_DCD3_2132_10D2);
    exp_blk = 16'd1;
    wait_done("blk_cnt_ones");

    // Back-pressure with late core response, then core_ready held high early
    bp_mode  = 1'b1;
    core_lat = 6;
    send_block(64'h0123_4567_89AB_CDEF, 1'b0, 64'h0);
    exp_blk = 16'd2;
    wait_done("blk_cnt_bp");
    core_early = 1'b1;
    send_block(64'hFEDC_BA98_7654_3210, 1'b0, 64'h0);
    exp_blk = 16'd3;
    wait_done("blk_cnt_early");
    core_early = 1'b0;
    bp_mode    = 1'b0;
    core_lat   = 2;

    // cfg_load at byte count 3 is ignored
    push_exp(64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 64'h0, 1'b1);
    send_range(64'hA5A5_5A5A_0F0F_F0F0, 0, 2);
    cfg_pulse(80'h1234_5678_9ABC_DEF0_1357, 64'h1111_1111_1111_1111, 1'b0, 8'h00);
    send_range(64'hA5A5_5A5A_0F0F_F0F0, 3, 7);
    exp_blk = 16'd4;
    wait_done("blk_cnt_cfg_mid");
    chk("key_after_ignored_cfg", core_key, m_key);

    // cfg_load together with in_valid at count 0: load wins, byte dropped
    cfg_pulse(80'h0F1E_2D3C_4B5A_6978_8796, 64'h0102_0304_0506_0708, 1'b1, 8'hAA);
    m_key   = 80'h0F1E_2D3C_4B5A_6978_8796;
    m_chain = 64'h0102_0304_0506_0708;
    chk("key_after_cfg", core_key, m_key);
    send_block(64'h3C3C_C3C3_9696_6969, 1'b0, 64'h0);
    exp_blk = 16'd1;
    wait_done("blk_cnt_cfg_load");

    // Reset in the first WAIT cycle
    core_hang = 1'b1;
    push_exp(64'h7777_8888_9999_AAAA, 1'b0, 64'h0, 1'b0);
    send_range(64'h7777_8888_9999_AAAA, 0, 7);
    @(posedge CK); #1;
    RN = 1'b1;
    @(negedge CK);
    chk("in_ready_in_rst", 80'(in_ready), 80'(0));
    @(posedge CK); #1;
    RN = 1'b0;
    core_hang = 1'b0;
    @(negedge CK);
    chk("midrst_core_start", 80'(core_start), 80'(0));
    chk("midrst_out_valid", 80'(out_valid), 80'(0));
    chk("midrst_in_ready", 80'(in_ready), 80'(1));
    chk("midrst_blk_cnt", 80'(blk_cnt), 80'(0));
    chk("midrst_core_key", core_key, 80'(0));
    @(posedge CK); #1;
    m_key   = '0;
    m_chain = '0;
    // chain cleared: core_ptext must equal the raw plaintext
    send_block(64'h1111_2222_3333_4444, 1'b0, 64'h0);
    exp_blk = 16'd1;
    wait_done("blk_cnt_after_midrst");

    // blk_cnt wrap-around
    @(negedge CK);
    force dut.blk_cnt_d = 16'hFFFF;
    @(posedge CK); #1;
    release dut.blk_cnt_d;
    @(negedge CK);
    chk("blk_cnt_forced", 80'(blk_cnt), 80'(16'hFFFF));
    @(posedge CK); #1;
    send_block(64'h5555_AAAA_5555_AAAA, 1'b0, 64'h0);
    exp_blk = 16'h0000;
    wait_done("blk_cnt_wrap");

    repeat (4) @(posedge CK);
    chk("exp_pt_queue_empty", 80'(exp_pt_q.size()), 80'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/present_cbc_stream.md
# present_cbc_stream

Byte-stream CBC front-end for the PRESENT-80 encryption core. Accepts plaintext as a valid/ready byte stream and packs eight bytes into a 64-bit block. Each block is XORed with the chaining value (IV, or the previous ciphertext) and handed to the core via its start/ready handshake. The returned ciphertext is serialized back out as a valid/ready byte stream. Sits directly upstream and downstream of the cipher core, wired to its `start`/`ptext`/`key`/`ready`/`ctext` ports.

## Interface
Parameters:
- `MSB_FIRST`, default 1: 1 = first byte maps to bits [63:56] in and out; 0 = first byte maps to [7:0].

Ports:
- `CK` in 1: single clock, rising edge.
- `RN` in 1: reset, synchronous, active-high.
- `cfg_load` in 1: load `cfg_key` and `cfg_iv`.
- `cfg_key` in 80: cipher key.
- `cfg_iv` in 64: initial chaining value.
- `in_data` in 8: plaintext byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: byte accepted when `in_valid & in_ready`.
- `out_data` out 8: ciphertext byte.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: byte consumed when `out_valid & out_ready`.
- `core_start` out 1: one-cycle start pulse to the core.
- `core_ptext` out 64: block XOR chain; held stable from the start pulse until capture.
- `core_key` out 80: registered key, stable between loads.
- `core_ready` in 1: core result valid.
- `core_ctext` in 64: core ciphertext.
- `blk_cnt` out 16: count of completed blocks.

## Operation
- FSM states: FILL, KICK, WAIT, DRAIN.
- **FILL**
  - `in_ready` = 1, except in a cycle where `cfg_load` = 1.
  - Each accepted byte shifts into the block register; the byte count increments 0..7.
  - On the 8th accept: register `core_ptext <= block ^ chain`, go to KICK.
- **KICK**
  - `core_start` = 1 for exactly one cycle; then go to WAIT.
- **WAIT**
  - `core_ready` is ignored in KICK and in the first WAIT cycle.
  - From the second WAIT cycle on, `core_ready` = 1 captures `core_ctext` into the output shift register and into `chain`, then goes to DRAIN.
- **DRAIN**
  - `out_valid` = 1; `out_data` = the current byte of the captured ctext.
  - Each out handshake advances one byte.
  - After the 8th handshake: `blk_cnt` increments, go to FILL with count 0.
- **cfg_load**
  - Honoured only in FILL with byte count 0: `core_key <= cfg_key`, `chain <= cfg_iv`, `blk_cnt <= 0`.
  - Ignored in all other states and counts.
  - Has priority over a simultaneous `in_valid` (`in_ready` is 0 that cycle).
- **blk_cnt** wraps 0xFFFF -> 0x0000 with no flag.
- **Back-pressure:** `out_ready` held low freezes DRAIN indefinitely; `in_ready` stays 0 throughout KICK, WAIT and DRAIN (no overlap).

## Timing
- Reset values:
  - state FILL; byte count 0; `chain`, `core_key`, `core_ptext` = 0.
  - `core_start` 0; `out_valid` 0; `out_data` 0x00; `blk_cnt` 0.
  - `in_ready` 0 while `RN` = 1, and 1 in the first cycle after release.
- **Latency:**
  - 8th input accept at edge N -> `core_start` high in cycle N+1.
  - `core_ready` sampled high at edge M -> `out_valid` high in cycle M+1.
- **Reset mid-operation** (any state): partial block discarded, core pulse suppressed, `chain` cleared. The host must reissue `cfg_load` before the next message.
- **Handshakes:** `out_data` is stable while `out_valid & !out_ready`. `core_ptext` and `core_key` do not change from KICK until capture.

## Structure
- Shared package `present_pkg`:
  - FSM state enum.
  - Constants `BLK_W`=64, `KEY_W`=80, `BYTES_PER_BLK`=8.
  - `rc`/round constants stay with the core.
- One natural sub-module: `present_byte_ser`, the 64-bit load/shift-out serializer with byte counter, used in DRAIN. The input packer stays inline.

## Test plan
- **Zero vector:** reset; `cfg_load` with key=0, IV=0; send 8×0x00; core model -> `core_ptext`=0x0000000000000000, one `core_start` pulse. Output bytes must be 55 79 C1 38 7B 22 84 45; `blk_cnt`=1.
- **Chaining:** continue with 8×0x00 -> `core_ptext`=0x5579C1387B228445 (chain XOR); output = core ciphertext of that value; `blk_cnt`=2.
- **All-ones vector:** key=all-F, IV=0, plaintext 8×0xFF -> output 33 33 DC D3 21 32 10 D2.
- **Back-pressure and ready timing:** `out_ready` toggled 1/0 each cycle and core ready asserted late -> byte order unchanged. A `core_ready` already high during KICK is not sampled early. `in_ready` stays 0 until the 8th output byte is consumed.
- **cfg_load edge cases:** `cfg_load` asserted with byte count 3 -> ignored, key/IV unchanged. `cfg_load` with `in_valid` at count 0 -> load wins, byte not accepted.
- **Reset and wrap-around:** `RN` pulsed during WAIT -> `core_start` 0, `out_valid` 0, `in_ready` 1 next cycle, `chain` = 0. Force `blk_cnt`=0xFFFF and complete one block -> `blk_cnt`=0x0000.
